n101_i2c_slave_ctrl: RTL and testbench
======================================

# n101_i2c_slave_ctrl

I2C target (slave) controller for the n101 peripheral subsystem; it is the responder-side counterpart of the I2C master byte/bit controllers. It filters SCL/SDA, detects START/STOP, matches a fixed 7-bit address, receives write bytes and transmits read bytes to the host register interface. It drives the bus open-drain, with `*_oen` active low. It stretches SCL while the host has no transmit byte ready.

## Interface
- `SLV_ADDR`, default 7'h50, 7-bit address this target answers to.
- `FILT`, default 3, number of consecutive equal samples required to accept a new SCL/SDA level (1..7).
- `clk` input 1: system clock.
- `nReset` input 1: reset, asynchronous, active-low.
- `rst` input 1: synchronous reset; same effect as `nReset`.
- `ena` input 1: core enable; 0 forces bus release and IDLE.
- `scl_i` input 1: SCL pad input.
- `scl_o` output 1: SCL output value, constant 0.
- `scl_oen` output 1: SCL output enable, active low; 0 means SCL is stretched.
- `sda_i` input 1: SDA pad input.
- `sda_o` output 1: SDA output value, constant 0.
- `sda_oen` output 1: SDA output enable, active low; 0 drives SDA low.
- `ack_in` input 1: ACK value to return for received write bytes (0=ACK, 1=NACK).
- `tx_data` input 8: next byte to transmit on a read.
- `tx_load` input 1: one-cycle strobe that captures `tx_data` into the tx buffer and sets `tx_full`.
- `tx_req` output 1: one-cycle pulse requesting the next read byte.
- `rx_data` output 8: last received data byte.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `ack_out` output 1: master's ACK/NACK sampled after the last transmitted byte.
- `addr_hit` output 1: high from address match until STOP or repeated START.
- `rw` output 1: R/W bit of the matched address byte (1 = read).
- `start_det` output 1: one-cycle pulse on START or repeated START.
- `stop_det` output 1: one-cycle pulse on STOP.
- `busy` output 1: high between START and STOP (any address).

## Operation
- Input path: 2-FF synchronizer, then a level filter; the filtered level changes only after `FILT` identical consecutive samples. All bus events use filtered `scl`/`sda` and their registered edges.
- START: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high. Either event is honoured in every state. Both release SDA and SCL.
  - START → ADDR, `bitcnt`=0, `addr_hit`=0.
  - STOP → IDLE, `addr_hit`=0, `busy`=0.
- Bits are sampled on the SCL rising edge. The slave changes SDA only on the SCL falling edge.
- States and transitions:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits MSB first. At the SCL fall after the 8th rise:
    - `[7:1]`==`SLV_ADDR` → `sda_oen`=0 (ACK), `rw`=bit0, `addr_hit`=1, go to ADDR_ACK.
    - No match → IGNORE (SDA released; waits for START/STOP).
  - ADDR_ACK: at the next SCL fall, release SDA. Go to RX if `rw`=0, else TX_LOAD.
  - RX: shift 8 bits. On the 8th rise: `rx_data` ← byte, `rx_valid` pulse. At the following fall, `sda_oen` ← `ack_in`; go to RX_ACK.
  - RX_ACK: release SDA at the next fall, return to RX. There is no overrun protection; the host must read within one byte time.
  - TX_LOAD:
    - If `tx_full`: load the shift register, clear `tx_full`, drive bit7 (`sda_oen`=bit), go to TX.
    - Otherwise: hold `scl_oen`=0 (SCL held low) until `tx_load` arrives, then do the same and release SCL one cycle after SDA is set.
    - `tx_req` pulses on entry to TX_LOAD.
  - TX: on each SCL fall, shift out the next bit. After the 8th bit's fall, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the rise into `ack_out`. At the next fall:
    - 0 (ACK) → TX_LOAD.
    - 1 (NACK) → IGNORE.
- `tx_load` while `tx_full`=1 overwrites the buffer.
- `rst` or `ena`=0: all state and outputs go to reset values next cycle. This includes mid-byte and mid-stretch.

## Timing
- Reset values:
  - `sda_oen`=1, `scl_oen`=1, `sda_o`=0, `scl_o`=0.
  - `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `ack_out`=0.
  - `addr_hit`=0, `rw`=0, `start_det`=0, `stop_det`=0, `busy`=0.
  - Internal: tx buffer 8'h00, `tx_full`=0, state IDLE, `bitcnt`=0.
- Pin-to-event latency: 2 + `FILT` clk cycles.
- Driven SDA changes exactly 1 clk after the detected SCL fall. The requirement clk ≥ 16× SCL guarantees data setup for standard and fast mode.
- `rx_valid`, `tx_req`, `start_det` and `stop_det` are single-cycle pulses, registered.
- A START and STOP detected in the same cycle is impossible (same SDA edge); STOP takes priority if a filter glitch ever produces both.
- A clock-stretch release waits for SCL to be released by this block; the master sees SCL high ≥1 clk after SDA is stable.

## Test plan
- Write 0xA0 then 0x3C, 0xFF with `ack_in`=0, STOP:
  - ACK on address and both bytes.
  - `rx_valid` pulses twice with `rx_data` 0x3C then 0xFF.
  - `stop_det` pulses; `busy` ends at 0.
- Address 0x52 (mismatch):
  - No ACK (SDA never driven), `addr_hit`=0, no `rx_valid`.
  - A subsequent START with 0xA0 is accepted.
- Read 0xA1 with `tx_data`=0x96 preloaded, master ACK then NACK, second byte 0x5A loaded on `tx_req`:
  - SDA bit stream reproduces 0x96, 0x5A.
  - `ack_out` is 0 then 1; the block returns to IGNORE.
- Read with no preload:
  - `scl_oen`=0 from the ACK-phase fall until `tx_load` arrives 200 cycles later.
  - SCL is released after the first bit is driven.
- Repeated START after a write byte (0xA0, 0x11, Sr, 0xA1):
  - `start_det` pulses twice.
  - `rw` changes 0→1; the transmit path is entered.
- `nReset` asserted mid-byte while SDA is driven low: `sda_oen`=1 and `scl_oen`=1 immediately; all outputs return to their reset values.

Source files
------------

// File: rtl/n101_i2c_slave_ctrl.sv
// n101 I2C target controller: filtered SCL/SDA, START/STOP detection,
// fixed 7-bit address match, write-byte receive and read-byte transmit
// with SCL stretching while no transmit byte is buffered.
module n101_i2c_slave_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         FILT     = 3
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       rst,
  input  logic       ena,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic       ack_in,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ack_out,
  output logic       addr_hit,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK, IGNORE
  } state_t;

  // Open-drain pads: only the enables ever change.
  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  // Clearing from rst or a disabled core behaves exactly like nReset.
  logic clr;
  assign clr = rst | ~ena;

  // Index 1 is SCL, index 0 is SDA.
  logic [1:0] pad_in, lvl, lvl_d;
  assign pad_in = {scl_i, sda_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic       s1_reg, s2_reg, lvl_reg, lvl_d_reg;
    logic [2:0] cnt_reg;
    // Two-stage synchroniser, then accept a new level after FILT equal samples.
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        s1_reg <= 1'b1; s2_reg <= 1'b1; lvl_reg <= 1'b1; lvl_d_reg <= 1'b1;
        cnt_reg <= 3'd0;
      end else if (clr) begin
        s1_reg <= 1'b1; s2_reg <= 1'b1; lvl_reg <= 1'b1; lvl_d_reg <= 1'b1;
        cnt_reg <= 3'd0;
      end else begin
        s1_reg    <= pad_in[gi];
        s2_reg    <= s1_reg;
        lvl_d_reg <= lvl_reg;
        if (s2_reg == lvl_reg) begin
          cnt_reg <= 3'd0;
        end else if (cnt_reg == 3'(FILT - 1)) begin
          lvl_reg <= s2_reg;
          cnt_reg <= 3'd0;
        end else begin
          cnt_reg <= cnt_reg + 3'd1;
        end
      end
    end
    assign lvl[gi]   = lvl_reg;
    assign lvl_d[gi] = lvl_d_reg;
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_f      = lvl[1];
  assign sda_f      = lvl[0];
  assign scl_rise   = lvl[1] & ~lvl_d[1];
  assign scl_fall   = ~lvl[1] & lvl_d[1];
  assign start_cond = ~lvl[0] & lvl_d[0] & scl_f;
  assign stop_cond  = lvl[0] & ~lvl_d[0] & scl_f;

  state_t     state_reg;
  logic [3:0] bitcnt_reg;
  logic [7:0] shift_reg, tx_buf_reg;
  logic       tx_full_reg;

  // Protocol FSM with registered bus enables, status flags and strobes.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE; bitcnt_reg <= 4'd0; shift_reg <= 8'h00;
      tx_buf_reg <= 8'h00; tx_full_reg <= 1'b0;
      sda_oen <= 1'b1; scl_oen <= 1'b1; rx_data <= 8'h00; rx_valid <= 1'b0;
      tx_req <= 1'b0; ack_out <= 1'b0; addr_hit <= 1'b0; rw <= 1'b0;
      start_det <= 1'b0; stop_det <= 1'b0; busy <= 1'b0;
    end else if (clr) begin
      state_reg <= IDLE; bitcnt_reg <= 4'd0; shift_reg <= 8'h00;
      tx_buf_reg <= 8'h00; tx_full_reg <= 1'b0;
      sda_oen <= 1'b1; scl_oen <= 1'b1; rx_data <= 8'h00; rx_valid <= 1'b0;
      tx_req <= 1'b0; ack_out <= 1'b0; addr_hit <= 1'b0; rw <= 1'b0;
      start_det <= 1'b0; stop_det <= 1'b0; busy <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (stop_cond) begin
        // STOP wins over a simultaneous START produced by a glitch.
        state_reg <= IDLE; bitcnt_reg <= 4'd0; addr_hit <= 1'b0; busy <= 1'b0;
        stop_det <= 1'b1; sda_oen <= 1'b1; scl_oen <= 1'b1;
      end else if (start_cond) begin
        state_reg <= ADDR; bitcnt_reg <= 4'd0; addr_hit <= 1'b0; busy <= 1'b1;
        start_det <= 1'b1; sda_oen <= 1'b1; scl_oen <= 1'b1;
      end else begin
        case (state_reg)
          ADDR: begin
            if (scl_rise) begin
              shift_reg  <= {shift_reg[6:0], sda_f};
              bitcnt_reg <= bitcnt_reg + 4'd1;
            end else if (scl_fall && bitcnt_reg == 4'd8) begin
              bitcnt_reg <= 4'd0;
              if (shift_reg[7:1] == SLV_ADDR) begin
                sda_oen <= 1'b0; rw <= shift_reg[0]; addr_hit <= 1'b1;
                state_reg <= ADDR_ACK;
              end else begin
                state_reg <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oen <= 1'b1;
              if (rw) begin
                state_reg <= TX_LOAD;
                tx_req    <= 1'b1;
              end else begin
                state_reg <= RX;
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shift_reg  <= {shift_reg[6:0], sda_f};
              bitcnt_reg <= bitcnt_reg + 4'd1;
              if (bitcnt_reg == 4'd7) begin
                rx_data  <= {shift_reg[6:0], sda_f};
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && bitcnt_reg == 4'd8) begin
              sda_oen <= ack_in; bitcnt_reg <= 4'd0; state_reg <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oen <= 1'b1; state_reg <= RX;
            end
          end
          TX_LOAD: begin
            // Stretch SCL until a byte is buffered; SCL is let go from TX.
            if (tx_full_reg) begin
              shift_reg <= tx_buf_reg; sda_oen <= tx_buf_reg[7];
              tx_full_reg <= 1'b0; bitcnt_reg <= 4'd1; state_reg <= TX;
            end else begin
              scl_oen <= 1'b0;
            end
          end
          TX: begin
            scl_oen <= 1'b1;
            if (scl_fall) begin
              if (bitcnt_reg == 4'd8) begin
                sda_oen <= 1'b1; bitcnt_reg <= 4'd0; state_reg <= TX_ACK;
              end else begin
                sda_oen    <= shift_reg[6];
                shift_reg  <= {shift_reg[6:0], 1'b0};
                bitcnt_reg <= bitcnt_reg + 4'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              ack_out <= sda_f;
            end else if (scl_fall) begin
              if (!ack_out) begin
                state_reg <= TX_LOAD;
                tx_req    <= 1'b1;
              end else begin
                state_reg <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
      // A host load after the FSM section so a same-cycle load is never lost.
      if (tx_load) begin
        tx_buf_reg  <= tx_data;
        tx_full_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_n101_i2c_slave_ctrl.sv
// Directed bench for n101_i2c_slave_ctrl: a bit-level I2C master model on an
// open-drain bus, a table of write transactions, and hand-written read,
// stretch, repeated-START and reset sequences.
module tb_n101_i2c_slave_ctrl;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_i, sda_i, scl_o, scl_oen, sda_o, sda_oen;
  logic       ack_in = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_req, rx_valid, ack_out, addr_hit, rw, start_det, stop_det, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  assign scl_i = scl_m & (scl_oen ? 1'b1 : scl_o);
  assign sda_i = sda_m & (sda_oen ? 1'b1 : sda_o);

  n101_i2c_slave_ctrl dut (
    .clk(clk), .nReset(nReset), .rst(rst), .ena(ena),
    .scl_i(scl_i), .scl_o(scl_o), .scl_oen(scl_oen),
    .sda_i(sda_i), .sda_o(sda_o), .sda_oen(sda_oen),
    .ack_in(ack_in), .tx_data(tx_data), .tx_load(tx_load), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .ack_out(ack_out),
    .addr_hit(addr_hit), .rw(rw), .start_det(start_det), .stop_det(stop_det),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor: pulse counters and a log of received bytes.
  int         rx_n = 0, txreq_n = 0, start_n = 0, stop_n = 0, drv_n = 0;
  logic [7:0] rx_log [64];
  always @(negedge clk) begin
    if (rx_valid && rx_n < 64) rx_log[rx_n] <= rx_data;
    if (rx_valid)  rx_n    <= rx_n + 1;
    if (tx_req)    txreq_n <= txreq_n + 1;
    if (start_det) start_n <= start_n + 1;
    if (stop_det)  stop_n  <= stop_n + 1;
    if (!sda_oen)  drv_n   <= drv_n + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for SCL to actually go high (slave may be stretching).
  task automatic wait_scl();
    for (int i = 0; i < 3000; i++) begin
      if (scl_i === 1'b1) break;
      tick(1);
    end
    if (scl_i !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL scl_timeout: got %0b, expected 1", scl_i);
    end
  endtask

  task automatic m_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl(); tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; wait_scl(); tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; wait_scl(); tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl(); tick(Q);
    b = sda_i;
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    send_bit(ack);
  endtask

  task automatic host_load(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1; tick(1);
    tx_load = 1'b0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack_in;
    logic       exp_aack;   // bus level seen in the address ACK slot
    logic       exp_dack;   // bus level seen in each data ACK slot
    logic       exp_hit;
    int         exp_rx;
  } wvec_t;

  wvec_t      vec [5];
  logic       a, a0, a1, bt;
  logic [7:0] d, d2;
  int         b_rx, b_req, b_start, b_stop, b_drv, held_bad;
  logic       prev_sda;

  initial begin
    vec[0] = '{8'hA0, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vec[1] = '{8'h52, 8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vec[2] = '{8'hA0, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    vec[3] = '{8'hA2, 8'h55, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vec[4] = '{8'hA0, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2};

    // Reset values
    tick(3);
    check("rst_sda_oen_async", sda_oen, 1'b1);
    nReset = 1'b1;
    tick(Q);
    check("rst_sda_oen", sda_oen, 1'b1);
    check("rst_scl_oen", scl_oen, 1'b1);
    check("rst_pads_o", {sda_o, scl_o}, 2'b00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {rx_valid, tx_req, start_det, stop_det}, 4'b0000);
    check("rst_flags", {ack_out, addr_hit, rw, busy}, 4'b0000);

    // Table-driven write transactions
    for (int r = 0; r < 5; r++) begin
      ack_in = vec[r].ack_in;
      b_rx = rx_n; b_start = start_n; b_stop = stop_n; b_drv = drv_n;
      m_start();
      check("wr_busy", busy, 1'b1);
      write_byte(vec[r].addr, a);
      check("wr_addr_ack", a, vec[r].exp_aack);
      check("wr_addr_hit", addr_hit, vec[r].exp_hit);
      if (vec[r].exp_hit) check("wr_rw", rw, 1'b0);
      write_byte(vec[r].d0, a0);
      write_byte(vec[r].d1, a1);
      check("wr_d0_ack", a0, vec[r].exp_dack);
      check("wr_d1_ack", a1, vec[r].exp_dack);
      m_stop();
      tick(Q);
      check("wr_rx_count", rx_n - b_rx, vec[r].exp_rx);
      if (vec[r].exp_rx == 2) begin
        check("wr_rx_byte0", rx_log[b_rx], vec[r].d0);
        check("wr_rx_byte1", rx_log[b_rx + 1], vec[r].d1);
      end
      check("wr_sda_driven", (drv_n != b_drv), vec[r].exp_hit);
      check("wr_start_cnt", start_n - b_start, 1);
      check("wr_stop_cnt", stop_n - b_stop, 1);
      check("wr_end_flags", {busy, addr_hit}, 2'b00);
      $display("[TB] write row %0d addr %02h acks %0b%0b%0b rx %0d", r, vec[r].addr,
               a, a0, a1, rx_n - b_rx);
    end
    ack_in = 1'b0;

    // Read with preload 0x96, second byte 0x5A supplied on tx_req
    host_load(8'h96);
    b_req = txreq_n;
    fork
      begin
        m_start();
        write_byte(8'hA1, a);
        check("rd_addr_ack", a, 1'b0);
        check("rd_rw", rw, 1'b1);
        read_byte(d, 1'b0);
        check("rd_byte0", d, 8'h96);
        check("rd_ack_out0", ack_out, 1'b0);
        read_byte(d2, 1'b1);
        check("rd_byte1", d2, 8'h5A);
        check("rd_ack_out1", ack_out, 1'b1);
        read_bit(bt);
        check("rd_ignore_sda", bt, 1'b1);
        m_stop();
        tick(Q);
        check("rd_txreq_cnt", txreq_n - b_req, 2);
      end
      begin
        for (int i = 0; i < 3000 && (txreq_n - b_req) < 2; i++) tick(1);
        check("rd_txreq_wait", (txreq_n - b_req) >= 2, 1'b1);
        host_load(8'h5A);
      end
    join
    $display("[TB] read %02h %02h ack_out %0b", d, d2, ack_out);

    // Read with no preload: stretch for 200 cycles, then load 0x4D
    b_req = txreq_n;
    m_start();
    write_byte(8'hA1, a);
    check("st_addr_ack", a, 1'b0);
    check("st_stretch_on", scl_oen, 1'b0);
    check("st_txreq", txreq_n - b_req, 1);
    fork
      begin
        read_byte(d, 1'b1);
      end
      begin
        held_bad = 0;
        repeat (200) begin
          tick(1);
          if (scl_oen !== 1'b0) held_bad++;
        end
        check("st_stretch_held", held_bad, 0);
        host_load(8'h4D);
        prev_sda = sda_oen;
        for (int i = 0; i < 50 && scl_oen !== 1'b1; i++) begin
          prev_sda = sda_oen;
          tick(1);
        end
        check("st_released", scl_oen, 1'b1);
        check("st_bit7_before_release", prev_sda, 1'b0);
      end
    join
    check("st_byte", d, 8'h4D);
    m_stop();
    tick(Q);
    $display("[TB] stretched read %02h", d);

    // Repeated START: write 0x11 to 0xA0, Sr, read 0xC3 from 0xA1
    host_load(8'hC3);
    b_start = start_n; b_rx = rx_n; b_req = txreq_n;
    m_start();
    write_byte(8'hA0, a);
    check("sr_addr_w_ack", a, 1'b0);
    check("sr_rw_w", rw, 1'b0);
    write_byte(8'h11, a);
    check("sr_data_ack", a, 1'b0);
    m_start();
    write_byte(8'hA1, a);
    check("sr_addr_r_ack", a, 1'b0);
    check("sr_rw_r", rw, 1'b1);
    read_byte(d, 1'b1);
    check("sr_read_byte", d, 8'hC3);
    m_stop();
    tick(Q);
    check("sr_start_cnt", start_n - b_start, 2);
    check("sr_rx_byte", rx_log[b_rx], 8'h11);
    check("sr_txreq", txreq_n - b_req, 1);
    $display("[TB] repeated start rx %02h tx %02h", rx_log[b_rx], d);

    // nReset while the address ACK is driving SDA low
    m_start();
    for (int i = 7; i >= 0; i--) send_bit(bt_of(8'hA1, i));
    check("nr_ack_driven", sda_oen, 1'b0);
    nReset = 1'b0;
    #2;
    check("nr_sda_oen", sda_oen, 1'b1);
    check("nr_scl_oen", scl_oen, 1'b1);
    check("nr_flags", {addr_hit, rw, busy, ack_out}, 4'b0000);
    check("nr_rx_data", rx_data, 8'h00);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(2);
    nReset = 1'b1;
    tick(Q);
    $display("[TB] async reset mid-byte done");

    // ena dropped during a clock stretch
    m_start();
    write_byte(8'hA1, a);
    check("en_stretch_on", scl_oen, 1'b0);
    ena = 1'b0;
    tick(1);
    check("en_scl_oen", scl_oen, 1'b1);
    check("en_flags", {addr_hit, rw, busy}, 3'b000);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
    ena = 1'b1;
    tick(Q);
    $display("[TB] ena drop during stretch done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic bt_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
